// File: rtl/sw_seq_streamer_if.sv
// rtl/sw_seq_streamer_if.sv - host load, control and PE-array stream bundle for sw_seq_streamer
//
// Purpose: groups every non-clock/reset signal of sw_seq_streamer.
//   slave  modport: the streamer itself.
//   master modport: host plus PE-array controller driving it.
// Signals:
//   i_load_valid/i_load_sel/i_load_sym, o_load_ready : host sequence load port
//   i_start, o_busy, o_done, o_err                   : run control and status
//   o_data_valid, o_s/o_s_last, i_update_s_w         : S head toward the array
//   o_t/o_v/o_f/o_t_last, i_update_t_w               : T/V/F head toward the array
//   i_t_valid, i_t/i_v/i_f                           : tuples returned by the last PE
interface sw_seq_streamer_if #(
  parameter int SCORE_W = 16
);
  logic               i_load_valid;
  logic               i_load_sel;
  logic [1:0]         i_load_sym;
  logic               o_load_ready;
  logic               i_start;
  logic               o_busy;
  logic               o_done;
  logic               o_err;
  logic               o_data_valid;
  logic               i_update_s_w;
  logic [1:0]         o_s;
  logic               o_s_last;
  logic               i_update_t_w;
  logic [1:0]         o_t;
  logic [SCORE_W-1:0] o_v;
  logic [SCORE_W-1:0] o_f;
  logic               o_t_last;
  logic               i_t_valid;
  logic [1:0]         i_t;
  logic [SCORE_W-1:0] i_v;
  logic [SCORE_W-1:0] i_f;

  modport slave (
    input  i_load_valid, i_load_sel, i_load_sym, i_start, i_update_s_w,
           i_update_t_w, i_t_valid, i_t, i_v, i_f,
    output o_load_ready, o_busy, o_done, o_err, o_data_valid, o_s, o_s_last,
           o_t, o_v, o_f, o_t_last
  );

  modport master (
    output i_load_valid, i_load_sel, i_load_sym, i_start, i_update_s_w,
           i_update_t_w, i_t_valid, i_t, i_v, i_f,
    input  o_load_ready, o_busy, o_done, o_err, o_data_valid, o_s, o_s_last,
           o_t, o_v, o_f, o_t_last
  );
endinterface

// File: rtl/sw_seq_streamer.sv
// rtl/sw_seq_streamer.sv - S/T sequence store and ping-pong T/V/F streamer for a PE array
//
// Purpose: stores host-loaded S and T sequences, serves PE_NUM S symbols per
// pass, streams T with carried V/F, and captures the tuples returned by the
// last PE into the opposite ping-pong half for the following pass.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : sw_seq_streamer_if.slave (load port, control/status, S and T/V/F
//           heads toward the array, return path from the array)
module sw_seq_streamer #(
  parameter int PE_NUM  = 64,
  parameter int SCORE_W = 16,
  parameter int S_DEPTH = 1024,
  parameter int T_DEPTH = 256
) (
  input logic              clk,
  input logic              rst_n,
  sw_seq_streamer_if.slave bus
);
  // S-side counters are wide enough to hold pass_base + PE_NUM without wrapping.
  localparam int SW = $clog2(S_DEPTH + PE_NUM + 1);
  localparam int TW = $clog2(T_DEPTH + 1);
  localparam int SA = $clog2(S_DEPTH);
  localparam int TA = $clog2(T_DEPTH);
  localparam int EW = 2 + 2 * SCORE_W;
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [SW-1:0] PE_STEP = SW'(PE_NUM);
  localparam logic [SW-1:0] S_MAX   = SW'(S_DEPTH);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_MAX   = TW'(T_DEPTH);

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, SWAP} state_t;
  state_t state, state_nxt;

  logic [1:0]    s_mem [S_DEPTH];
  logic [EW-1:0] t_mem [2][T_DEPTH];   // {t, v, f} per entry, two ping-pong halves

  logic [SW-1:0] s_len, s_ptr, pass_base;
  logic [TW-1:0] t_len, t_ptr, wr_ptr;
  logic          rd_half, dv, done, err;
  logic [1:0]    s_head;
  logic [EW-1:0] t_head;

  logic [SW-1:0] pass_next, pass_end;
  logic          s_ok, t_at_last, wr_full;
  logic          s_load, t_load, ret_wr, s_adv, t_adv, err_set, done_set, go;

  // The current pass may serve S up to the pass boundary or the end of S.
  assign pass_next = pass_base + PE_STEP;
  assign pass_end  = (pass_next < s_len) ? pass_next : s_len;
  assign s_ok      = s_ptr < pass_end;
  assign t_at_last = (t_ptr == t_len - T_ONE);
  assign wr_full   = (wr_ptr == t_len);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_load    = 1'b0;
    t_load    = 1'b0;
    ret_wr    = 1'b0;
    s_adv     = 1'b0;
    t_adv     = 1'b0;
    err_set   = 1'b0;
    done_set  = 1'b0;
    go        = 1'b0;
    case (state)
      IDLE: begin
        // A load wins over a simultaneous start.
        if (bus.i_load_valid) begin
          if (!bus.i_load_sel) begin
            if (s_len < S_MAX) s_load = 1'b1;
            else               err_set = 1'b1;
          end else begin
            if (t_len < T_MAX) t_load = 1'b1;
            else               err_set = 1'b1;
          end
        end else if (bus.i_start) begin
          if (s_len == '0 || t_len == '0) begin
            done_set = 1'b1;
          end else begin
            go        = 1'b1;
            state_nxt = PRIME;
          end
        end
      end
      PRIME: state_nxt = STREAM;
      STREAM: begin
        if (bus.i_update_s_w) begin
          if (s_ok) s_adv   = 1'b1;
          else      err_set = 1'b1;
        end
        if (bus.i_update_t_w) begin
          t_adv = 1'b1;
          if (t_at_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.i_update_t_w) err_set = 1'b1;
        if (wr_full) state_nxt = SWAP;
      end
      SWAP: begin
        if (pass_next >= s_len) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end else begin
          state_nxt = PRIME;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if ((state == STREAM || state == DRAIN) && bus.i_t_valid) begin
      if (wr_full) err_set = 1'b1;
      else         ret_wr  = 1'b1;
    end
  end

  // Host T loads (IDLE only) and returned tuples (STREAM/DRAIN only) never coincide.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (s_load) s_mem[SA'(s_len)] <= bus.i_load_sym;
      if (t_load) t_mem[0][TA'(t_len)] <= {bus.i_load_sym, {(2 * SCORE_W){1'b0}}};
      if (ret_wr) t_mem[~rd_half][TA'(wr_ptr)] <= {bus.i_t, bus.i_v, bus.i_f};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_len     <= '0;
      s_ptr     <= '0;
      pass_base <= '0;
      t_len     <= '0;
      t_ptr     <= '0;
      wr_ptr    <= '0;
      rd_half   <= 1'b0;
      dv        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      s_head    <= '0;
      t_head    <= '0;
    end else begin
      done <= done_set;
      if (err_set) err <= 1'b1;
      if (s_load) s_len <= s_len + S_ONE;
      if (t_load) t_len <= t_len + T_ONE;
      if (go) begin
        pass_base <= '0;
        rd_half   <= 1'b0;
        wr_ptr    <= '0;
      end
      if (state == PRIME) begin
        s_ptr  <= pass_base;
        s_head <= s_mem[SA'(pass_base)];
        t_ptr  <= '0;
        t_head <= t_mem[rd_half][0];
        dv     <= 1'b1;
      end
      // Heads are prefetched from ptr+1 so a consume shows the next symbol with no bubble.
      if (s_adv) begin
        s_ptr  <= s_ptr + S_ONE;
        s_head <= s_mem[SA'(s_ptr + S_ONE)];
      end
      if (t_adv) begin
        if (t_at_last) begin
          dv <= 1'b0;
        end else begin
          t_ptr  <= t_ptr + T_ONE;
          t_head <= t_mem[rd_half][TA'(t_ptr + T_ONE)];
        end
      end
      if (ret_wr) wr_ptr <= wr_ptr + T_ONE;
      if (state == SWAP) begin
        rd_half   <= ~rd_half;
        t_ptr     <= '0;
        wr_ptr    <= '0;
        pass_base <= pass_next;
      end
    end
  end

  assign bus.o_load_ready = (state == IDLE);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_done       = done;
  assign bus.o_err        = err;
  assign bus.o_data_valid = dv;
  assign bus.o_s          = s_head;
  assign bus.o_s_last     = dv && (s_ptr == s_len - S_ONE);
  assign bus.o_t          = t_head[EW-1 -: 2];
  assign bus.o_v          = t_head[2*SCORE_W-1 -: SCORE_W];
  assign bus.o_f          = t_head[SCORE_W-1:0];
  assign bus.o_t_last     = dv && t_at_last;
endmodule

// File: tb/tb_sw_seq_streamer.sv
// tb/tb_sw_seq_streamer.sv - randomized self-checking bench for sw_seq_streamer
module tb_sw_seq_streamer;
  localparam int PE  = 4;
  localparam int SCW = 8;
  localparam int SD  = 16;
  localparam int TD  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_seq_streamer_if #(.SCORE_W(SCW)) bus();
  sw_seq_streamer #(.PE_NUM(PE), .SCORE_W(SCW), .S_DEPTH(SD), .T_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int done_seen;
  bit exp_err;

  logic [1:0]     s_q[$];
  logic [1:0]     t_q[$];
  logic [1:0]     cur_t [TD];
  logic [SCW-1:0] cur_v [TD];
  logic [SCW-1:0] cur_f [TD];
  logic [1:0]     nxt_t [TD];
  logic [SCW-1:0] nxt_v [TD];
  logic [SCW-1:0] nxt_f [TD];
  logic [1:0]     tab_t [3] = '{2'd3, 2'd2, 2'd1};
  logic [SCW-1:0] tab_v [3] = '{8'd5, 8'd7, 8'd9};
  logic [SCW-1:0] tab_f [3] = '{8'd1, 8'd0, 8'd2};
  localparam logic [26:0] RESET_OUTS = {1'b1, 26'd0};

  function automatic logic [26:0] outs();
    return {bus.o_load_ready, bus.o_busy, bus.o_done, bus.o_err, bus.o_data_valid,
            bus.o_s, bus.o_s_last, bus.o_t, bus.o_v, bus.o_f, bus.o_t_last};
  endfunction

  task automatic idle_inputs();
    bus.i_load_valid = 1'b0; bus.i_load_sel = 1'b0; bus.i_load_sym = 2'd0;
    bus.i_start = 1'b0; bus.i_update_s_w = 1'b0; bus.i_update_t_w = 1'b0;
    bus.i_t_valid = 1'b0; bus.i_t = 2'd0; bus.i_v = '0; bus.i_f = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_q.delete();
    t_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic load(input bit sel, input logic [1:0] sym);
    bus.i_load_valid = 1'b1; bus.i_load_sel = sel; bus.i_load_sym = sym;
    @(negedge clk);
    bus.i_load_valid = 1'b0;
    if (!sel) begin
      if (s_q.size() < SD) s_q.push_back(sym); else exp_err = 1'b1;
    end else begin
      if (t_q.size() < TD) t_q.push_back(sym); else exp_err = 1'b1;
    end
  endtask

  task automatic load_random(input int sl, input int tl);
    for (int i = 0; i < sl; i++) load(1'b0, 2'($urandom));
    for (int i = 0; i < tl; i++) load(1'b1, 2'($urandom));
  endtask

  // Plays the PE array: mode 0 random gaps, 1 continuous, 2 V = pass*10+index,
  // 3 fixed return table. inj 1/2/3 plants one protocol error in pass 0.
  task automatic run_passes(input int mode, input int inj);
    int sl, tl, npass, base, s_cnt, s_idx, t_idx, r_idx, cyc;
    bit injected;
    logic e;
    logic [1:0] rt;
    logic [SCW-1:0] rv, rf;
    sl = s_q.size();
    tl = t_q.size();
    for (int i = 0; i < tl; i++) begin cur_t[i] = t_q[i]; cur_v[i] = '0; cur_f[i] = '0; end
    npass = (sl + PE - 1) / PE;
    done_seen = 0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_data_valid !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_load_ready !== 1'b0) begin
      errors++;
      $display("FAIL prime: dv=%b busy=%b ready=%b expected 0 1 0", bus.o_data_valid, bus.o_busy, bus.o_load_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.o_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: dv=%b expected 1 two cycles after start", bus.o_data_valid);
    end
    for (int p = 0; p < npass; p++) begin
      base = p * PE;
      s_cnt = (sl - base < PE) ? sl - base : PE;
      s_idx = 0; t_idx = 0; r_idx = 0; cyc = 0;
      injected = (inj == 0) || (p != 0);
      if (p > 0) begin
        while (bus.o_data_valid !== 1'b1 && cyc < 20) begin
          @(negedge clk);
          if (bus.o_done === 1'b1) done_seen++;
          cyc++;
        end
        checks++;
        if (bus.o_data_valid !== 1'b1) begin
          errors++;
          $display("FAIL pass_start: pass %0d dv=%b expected 1", p, bus.o_data_valid);
        end
        cyc = 0;
      end
      while (!(s_idx == s_cnt && t_idx == tl && r_idx == tl && injected) && cyc < 400) begin
        idle_inputs();
        if (bus.o_data_valid === 1'b1 && s_idx < s_cnt && (mode == 1 || $urandom_range(0, 1) == 1)) begin
          checks++;
          if (bus.o_s !== s_q[base+s_idx] || bus.o_s_last !== (base + s_idx == sl - 1)) begin
            errors++;
            $display("FAIL s_head: pass %0d idx %0d o_s=%0d last=%b expected %0d %b", p, s_idx,
                     bus.o_s, bus.o_s_last, s_q[base+s_idx], (base + s_idx == sl - 1));
          end
          bus.i_update_s_w = 1'b1;
          s_idx++;
        end else if (!injected && inj == 1 && s_idx == s_cnt) begin
          bus.i_update_s_w = 1'b1;
          injected = 1'b1;
        end
        if (bus.o_data_valid === 1'b1 && t_idx < tl &&
            (t_idx < tl - 1 || (s_idx == s_cnt && (injected || inj != 1))) &&
            (mode == 1 || $urandom_range(0, 1) == 1)) begin
          checks++;
          if (bus.o_t !== cur_t[t_idx] || bus.o_v !== cur_v[t_idx] || bus.o_f !== cur_f[t_idx] ||
              bus.o_t_last !== (t_idx == tl - 1)) begin
            errors++;
            $display("FAIL t_head: pass %0d idx %0d t/v/f/last=%0d/%0d/%0d/%b expected %0d/%0d/%0d/%b",
                     p, t_idx, bus.o_t, bus.o_v, bus.o_f, bus.o_t_last,
                     cur_t[t_idx], cur_v[t_idx], cur_f[t_idx], (t_idx == tl - 1));
          end
          bus.i_update_t_w = 1'b1;
          t_idx++;
        end else if (!injected && inj == 2 && t_idx == tl) begin
          bus.i_update_t_w = 1'b1;
          injected = 1'b1;
        end
        if (r_idx < t_idx && (mode == 1 || $urandom_range(0, 1) == 1)) begin
          rt = 2'($urandom); rv = SCW'($urandom); rf = SCW'($urandom);
          if (mode == 2) rv = SCW'(p * 10 + r_idx);
          if (mode == 3) begin rt = tab_t[r_idx]; rv = tab_v[r_idx]; rf = tab_f[r_idx]; end
          nxt_t[r_idx] = rt; nxt_v[r_idx] = rv; nxt_f[r_idx] = rf;
          bus.i_t_valid = 1'b1; bus.i_t = rt; bus.i_v = rv; bus.i_f = rf;
          r_idx++;
        end else if (!injected && inj == 3 && r_idx == tl) begin
          bus.i_t_valid = 1'b1; bus.i_t = 2'($urandom); bus.i_v = SCW'($urandom); bus.i_f = SCW'($urandom);
          injected = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (bus.o_done === 1'b1) done_seen++;
      end
      idle_inputs();
      checks++;
      if (cyc >= 400) begin
        errors++;
        $display("FAIL pass_timeout: pass %0d s=%0d t=%0d r=%0d expected %0d %0d %0d", p, s_idx, t_idx, r_idx, s_cnt, tl, tl);
      end
      for (int i = 0; i < tl; i++) begin cur_t[i] = nxt_t[i]; cur_v[i] = nxt_v[i]; cur_f[i] = nxt_f[i]; end
    end
    // Last return lands, DRAIN sees the buffer full, SWAP, then done.
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL done_early1: o_done=%b expected 0", bus.o_done); end
    @(negedge clk);
    if (bus.o_done === 1'b1) done_seen++;
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL done_early2: o_done=%b expected 0", bus.o_done); end
    @(negedge clk);
    if (bus.o_done === 1'b1) done_seen++;
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: o_done=%b o_busy=%b expected 1 0", bus.o_done, bus.o_busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL done_count: %0d pulses expected 1", done_seen); end
    e = exp_err || (inj != 0);
    checks++;
    if (bus.o_err !== e) begin errors++; $display("FAIL err_flag: o_err=%b expected %b", bus.o_err, e); end
  endtask

  task automatic check_empty_start(input string name);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: o_done=%b o_busy=%b expected 1 0", name, bus.o_done, bus.o_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: o_done=%b o_busy=%b expected 0 0", name, bus.o_done, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== RESET_OUTS) begin errors++; $display("FAIL reset_outs: %h expected %h", outs(), RESET_OUTS); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 4; i++) load(1'b0, 2'(i));
    for (int i = 0; i < 3; i++) load(1'b1, 2'(3 - i));
    run_passes(3, 0);
  endtask

  task automatic test_multipass();
    do_reset();
    load_random(9, 2);
    run_passes(2, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_random(12, 5);
    run_passes(1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load_random($urandom_range(1, SD), $urandom_range(1, TD));
      run_passes(0, 0);
    end
  endtask

  task automatic test_errors();
    for (int inj = 1; inj <= 3; inj++) begin
      do_reset();
      load_random(8, 3);
      run_passes(0, inj);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    load_random(5, TD + 1);
    run_passes(0, 0);
  endtask

  task automatic test_empty();
    do_reset();
    load_random(0, 2);
    check_empty_start("empty_s");
    do_reset();
    load_random(3, 0);
    check_empty_start("empty_t");
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_random(4, 3);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_update_s_w = 1'b1;
    bus.i_update_t_w = 1'b1;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (outs() !== RESET_OUTS) begin errors++; $display("FAIL mid_reset_outs: %h expected %h", outs(), RESET_OUTS); end
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL mid_reset_done: %0d pulses expected 0", done_seen); end
    check_empty_start("mid_reset_restart");
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_multipass();
    test_back_to_back();
    test_random();
    test_errors();
    test_overflow();
    test_empty();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
